// File: rtl/regfile_pkg.sv
// Shared types and sizing helpers for the multi-port register file.
package regfile_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    // Register 0 is hardwired to zero and can never hold a reservation.
    localparam int ZERO_ADDR = 0;

    function automatic int rf_depth(input int addr_w);
        return 1 << addr_w;
    endfunction

    // One extra bit so the pointer can run past the last register without wrapping.
    function automatic int rf_ptr_w(input int addr_w);
        return addr_w + 1;
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits: reservations set, writebacks clear, set wins on a collision.
// With REGFILE_BYPASS_EN a forwarded read reports not-busy unless re-reserved that cycle.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     run,
    input  logic                     rsv_en,
    input  logic [ADDR_W-1:0]        rsv_addr,
    input  logic                     wa_en,
    input  logic [ADDR_W-1:0]        wa_addr,
    input  logic                     wb_en,
    input  logic [ADDR_W-1:0]        wb_addr,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD-1:0]        rd_busy
);

    localparam int DEPTH = rf_depth(ADDR_W);

    logic [DEPTH-1:0] busy_reg;
    logic [DEPTH-1:0] busy_next;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_bit
            if (gi == ZERO_ADDR) begin : g_zero
                assign busy_next[gi] = 1'b0;
            end else begin : g_live
                logic set_hit;
                logic clr_hit;
                assign set_hit = run && rsv_en && (rsv_addr == ADDR_W'(gi));
                assign clr_hit = run && ((wa_en && (wa_addr == ADDR_W'(gi))) ||
                                         (wb_en && (wb_addr == ADDR_W'(gi))));
                // A reservation is a newer producer than the write retiring now.
                assign busy_next[gi] = set_hit | (busy_reg[gi] & ~clr_hit);
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_reg <= '0;
        end else begin
            busy_reg <= busy_next;
        end
    end

    generate
        for (gi = 0; gi < NUM_RD; gi++) begin : g_port
            logic [ADDR_W-1:0] addr;
            assign addr = rd_addr[gi*ADDR_W +: ADDR_W];
`ifdef REGFILE_BYPASS_EN
            logic fwd;
            assign fwd = ((wa_en && (wa_addr == addr)) || (wb_en && (wb_addr == addr))) &&
                         !(rsv_en && (rsv_addr == addr));
            assign rd_busy[gi] = run && busy_reg[addr] && !fwd;
`else
            assign rd_busy[gi] = run && busy_reg[addr];
`endif
        end
    endgenerate

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: NUM_RD async reads, prioritised write ports A/B, post-reset clear.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to matching read ports.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    output logic                     ready,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic                     wa_en,
    input  logic [ADDR_W-1:0]        wa_addr,
    input  logic [DATA_W-1:0]        wa_data,
    input  logic                     wb_en,
    input  logic [ADDR_W-1:0]        wb_addr,
    input  logic [DATA_W-1:0]        wb_data,
    input  logic                     rsv_en,
    input  logic [ADDR_W-1:0]        rsv_addr
);

    localparam int DEPTH = rf_depth(ADDR_W);
    localparam int PTR_W = rf_ptr_w(ADDR_W);

    state_t            state_reg, state_next;
    logic [PTR_W-1:0]  clr_ptr_reg, clr_ptr_next;
    logic              ready_reg, ready_next;
    logic [DATA_W-1:0] mem_reg [DEPTH];
    logic              run;

    assign run   = (state_reg == RUN);
    assign ready = ready_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= CLEAR;
            clr_ptr_reg <= '0;
            ready_reg   <= 1'b0;
        end else begin
            state_reg   <= state_next;
            clr_ptr_reg <= clr_ptr_next;
            ready_reg   <= ready_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        clr_ptr_next = clr_ptr_reg;
        ready_next   = ready_reg;
        case (state_reg)
            CLEAR: begin
                clr_ptr_next = clr_ptr_reg + 1'b1;
                if (clr_ptr_reg == PTR_W'(DEPTH - 1)) begin
                    state_next = RUN;
                    ready_next = 1'b1;
                end
            end
            RUN: begin
                ready_next = 1'b1;
            end
            default: begin
                state_next = CLEAR;
            end
        endcase
    end

    // Port B is written last so it wins when both ports hit the same register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state_reg == CLEAR) begin
                mem_reg[clr_ptr_reg[ADDR_W-1:0]] <= '0;
            end else begin
                if (wa_en && (wa_addr != ADDR_W'(ZERO_ADDR))) begin
                    mem_reg[wa_addr] <= wa_data;
                end
                if (wb_en && (wb_addr != ADDR_W'(ZERO_ADDR))) begin
                    mem_reg[wb_addr] <= wb_data;
                end
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
            logic [ADDR_W-1:0] addr;
            logic [DATA_W-1:0] word;
            assign addr = rd_addr[gi*ADDR_W +: ADDR_W];
`ifdef REGFILE_BYPASS_EN
            assign word = (wb_en && (wb_addr == addr)) ? wb_data :
                          (wa_en && (wa_addr == addr)) ? wa_data : mem_reg[addr];
`else
            assign word = mem_reg[addr];
`endif
            assign rd_data[gi*DATA_W +: DATA_W] =
                (run && (addr != ADDR_W'(ZERO_ADDR))) ? word : '0;
        end
    endgenerate

    regfile_scoreboard #(
        .ADDR_W (ADDR_W),
        .NUM_RD (NUM_RD)
    ) u_scoreboard (
        .clk      (clk),
        .rst      (rst),
        .run      (run),
        .rsv_en   (rsv_en),
        .rsv_addr (rsv_addr),
        .wa_en    (wa_en),
        .wa_addr  (wa_addr),
        .wb_en    (wb_en),
        .wb_addr  (wb_addr),
        .rd_addr  (rd_addr),
        .rd_busy  (rd_busy)
    );

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: directed plan steps plus a randomized phase
// checked against an array/flag reference model.
module tb_regfile_mp;

    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int NR    = 3;
    localparam int DEPTH = 1 << AW;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            ready;
    logic [NR*AW-1:0] rd_addr = '0;
    logic [NR*DW-1:0] rd_data;
    logic [NR-1:0]   rd_busy;
    logic            wa_en = 1'b0;
    logic [AW-1:0]   wa_addr = '0;
    logic [DW-1:0]   wa_data = '0;
    logic            wb_en = 1'b0;
    logic [AW-1:0]   wb_addr = '0;
    logic [DW-1:0]   wb_data = '0;
    logic            rsv_en = 1'b0;
    logic [AW-1:0]   rsv_addr = '0;

    regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR)) dut (
        .clk      (clk),
        .rst      (rst),
        .ready    (ready),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .rd_busy  (rd_busy),
        .wa_en    (wa_en),
        .wa_addr  (wa_addr),
        .wa_data  (wa_data),
        .wb_en    (wb_en),
        .wb_addr  (wb_addr),
        .wb_data  (wb_data),
        .rsv_en   (rsv_en),
        .rsv_addr (rsv_addr)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: register contents, busy flags, ready flag and clear progress.
    logic [DW-1:0] m_mem [DEPTH];
    bit            m_busy [DEPTH];
    bit            m_ready = 1'b0;
    int            m_cleared = 0;
    bit            m_valid = 1'b0;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int rd_a(input int p);
        return int'(rd_addr[p*AW +: AW]);
    endfunction

    task automatic set_rd(input int p, input int a);
        logic [AW-1:0] av;
        av = AW'(a);
        rd_addr[p*AW +: AW] = av;
    endtask

    function automatic logic [DW-1:0] exp_data(input int a);
        if (!m_ready || a == 0) return '0;
`ifdef REGFILE_BYPASS_EN
        if (wb_en && int'(wb_addr) == a) return wb_data;
        if (wa_en && int'(wa_addr) == a) return wa_data;
`endif
        return m_mem[a];
    endfunction

    function automatic logic exp_busy(input int a);
        if (!m_ready || a == 0) return 1'b0;
`ifdef REGFILE_BYPASS_EN
        if (((wa_en && int'(wa_addr) == a) || (wb_en && int'(wb_addr) == a)) &&
            !(rsv_en && int'(rsv_addr) == a)) return 1'b0;
`endif
        return m_busy[a];
    endfunction

    task automatic model_edge();
        if (rst) begin
            m_ready   = 1'b0;
            m_cleared = 0;
            for (int i = 0; i < DEPTH; i++) m_busy[i] = 1'b0;
            m_valid = 1'b1;
        end else if (!m_ready) begin
            m_mem[m_cleared] = '0;
            m_cleared++;
            if (m_cleared == DEPTH) m_ready = 1'b1;
        end else begin
            if (wa_en && wa_addr != 0) m_mem[wa_addr] = wa_data;
            if (wb_en && wb_addr != 0) m_mem[wb_addr] = wb_data;
            if (wa_en) m_busy[wa_addr] = 1'b0;
            if (wb_en) m_busy[wb_addr] = 1'b0;
            if (rsv_en) m_busy[rsv_addr] = 1'b1;
            m_busy[0] = 1'b0;
        end
    endtask

    // Called just after a negedge with inputs applied: check outputs, clock once, update model.
    task automatic cycle();
        #1;
        if (m_valid) begin
            chk("ready", {31'b0, ready}, {31'b0, m_ready});
            for (int p = 0; p < NR; p++) begin
                chk($sformatf("rd_data[%0d] a=%0d", p, rd_a(p)), rd_data[p*DW +: DW], exp_data(rd_a(p)));
                chk($sformatf("rd_busy[%0d] a=%0d", p, rd_a(p)), {31'b0, rd_busy[p]}, {31'b0, exp_busy(rd_a(p))});
            end
        end
        @(posedge clk);
        model_edge();
        @(negedge clk);
        $display("t=%0t rst=%0b wa=%0b/%0d/%h wb=%0b/%0d/%h rsv=%0b/%0d ready=%0b",
                 $time, rst, wa_en, wa_addr, wa_data, wb_en, wb_addr, wb_data,
                 rsv_en, rsv_addr, ready);
    endtask

    task automatic idle();
        wa_en = 1'b0; wb_en = 1'b0; rsv_en = 1'b0;
    endtask

    task automatic reset_and_clear(input int abort_at);
        int n;
        idle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        if (abort_at > 0) begin
            for (int i = 0; i < abort_at; i++) cycle();
            rst = 1'b1;
            cycle();
            rst = 1'b0;
        end
        n = 0;
        while (ready === 1'b0 && n < 100) begin
            n++;
            cycle();
        end
        chk("ready_low_cycles", DW'(n), DW'(DEPTH));
    endtask

    task automatic check_all_zero();
        for (int a = 0; a < DEPTH; a += NR) begin
            for (int p = 0; p < NR; p++) set_rd(p, (a + p) % DEPTH);
            #1;
            for (int p = 0; p < NR; p++)
                chk($sformatf("cleared a=%0d", (a + p) % DEPTH), rd_data[p*DW +: DW], '0);
            cycle();
        end
    endtask

    initial begin
        // 1: reset, exactly DEPTH clear cycles, everything reads zero
        reset_and_clear(0);
        check_all_zero();

        // 2: basic write then read; write to address 0 is discarded
        wa_en = 1'b1; wa_addr = 5; wa_data = 32'hDEADBEEF; set_rd(0, 1);
        cycle();
        idle(); set_rd(0, 5);
        #1 chk("wr_rd_addr5", rd_data[0 +: DW], 32'hDEADBEEF);
        cycle();
        wa_en = 1'b1; wa_addr = 0; wa_data = 32'h1234;
        cycle();
        idle(); set_rd(0, 0);
        #1 chk("addr0_reads0", rd_data[0 +: DW], '0);
        cycle();

        // 3: both ports on one address, port B wins
        wa_en = 1'b1; wa_addr = 7; wa_data = 32'h11;
        wb_en = 1'b1; wb_addr = 7; wb_data = 32'h22;
        cycle();
        idle(); set_rd(1, 7);
        #1 chk("dual_write_b_wins", rd_data[DW +: DW], 32'h22);
        cycle();

        // 4: scoreboard set, clear, and set-beats-clear
        rsv_en = 1'b1; rsv_addr = 9;
        cycle();
        idle(); set_rd(0, 9);
        #1 chk("busy_after_rsv", {31'b0, rd_busy[0]}, 32'd1);
        wb_en = 1'b1; wb_addr = 9; wb_data = 32'h99;
        cycle();
        idle();
        #1 chk("busy_after_write", {31'b0, rd_busy[0]}, 32'd0);
        rsv_en = 1'b1; rsv_addr = 9; wa_en = 1'b1; wa_addr = 9; wa_data = 32'h9A;
        cycle();
        idle();
        #1 chk("busy_set_wins", {31'b0, rd_busy[0]}, 32'd1);
        rsv_en = 1'b1; rsv_addr = 0;
        cycle();
        idle(); set_rd(2, 0);
        #1 chk("busy_addr0_never", {31'b0, rd_busy[2]}, 32'd0);
        cycle();

        // 6: same-cycle read of a register being written
        wa_en = 1'b1; wa_addr = 3; wa_data = 32'h55;
        cycle();
        wa_en = 1'b1; wa_addr = 3; wa_data = 32'hAA; set_rd(0, 3);
`ifdef REGFILE_BYPASS_EN
        #1 chk("same_cycle_bypass", rd_data[0 +: DW], 32'hAA);
`else
        #1 chk("same_cycle_old", rd_data[0 +: DW], 32'h55);
`endif
        cycle();
        idle();
        #1 chk("next_cycle_new", rd_data[0 +: DW], 32'hAA);
        cycle();

        // Randomized traffic, narrow address range to force collisions
        for (int k = 0; k < 400; k++) begin
            wa_en = 1'($urandom_range(0, 1)); wa_addr = AW'($urandom_range(0, 11)); wa_data = $urandom;
            wb_en = 1'($urandom_range(0, 1)); wb_addr = AW'($urandom_range(0, 11)); wb_data = $urandom;
            rsv_en = 1'($urandom_range(0, 1)); rsv_addr = AW'($urandom_range(0, 11));
            for (int p = 0; p < NR; p++) set_rd(p, $urandom_range(0, 11));
            cycle();
        end
        idle();

        // 5: preload stale data, abort the clear at pointer 10, check full restart
        for (int a = 1; a < DEPTH; a++) begin
            wa_en = 1'b1; wa_addr = AW'(a); wa_data = 32'hBAD00000 | a;
            cycle();
        end
        reset_and_clear(10);
        check_all_zero();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
Parametrised multi-port register file, successor to the single-write, two-read MIPS register file.
- N combinational read ports and two synchronous write ports (A, B) with fixed priority.
- Hardware clear of the whole array after reset, with a ready flag.
- Per-register busy scoreboard so the decode stage can detect pending producers.
- Sits between decode (reads, reservations) and writeback (ALU on port A, load/memory on port B).

Parameters:
DATA_W, 32, register width in bits
ADDR_W, 5, register address width; DEPTH = 2**ADDR_W
NUM_RD, 2, number of read ports (1..4)

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous, active-high reset
ready  out  1  1 = array cleared, writes and reservations accepted
rd_addr  in  NUM_RD*ADDR_W  read addresses; port i at bits [i*ADDR_W +: ADDR_W]
rd_data  out  NUM_RD*DATA_W  read data, same packing
rd_busy  out  NUM_RD  1 = addressed register has an outstanding reservation
wa_en  in  1  write port A enable
wa_addr  in  ADDR_W  write port A address
wa_data  in  DATA_W  write port A data
wb_en  in  1  write port B enable
wb_addr  in  ADDR_W  write port B address
wb_data  in  DATA_W  write port B data
rsv_en  in  1  reserve (mark busy) register rsv_addr
rsv_addr  in  ADDR_W  register to reserve

Behaviour:
- State machine, two states, CLEAR and RUN.
  - rst=1 at an edge: state<=CLEAR, clear pointer<=0, all busy bits<=0, ready<=0.
  - Applies from any state, including mid-clear; a mid-clear reset restarts the pointer at 0.
- CLEAR:
  - One register zeroed per cycle at the clear pointer; pointer increments.
  - After writing DEPTH-1: state<=RUN, ready<=1 on the following edge.
  - Clear therefore takes DEPTH cycles after rst deasserts.
  - wa_en, wb_en and rsv_en are ignored.
  - rd_data = 0 and rd_busy = 0 on all ports.
- RUN, reads:
  - Combinational, zero latency: rd_data[i] = array[rd_addr[i]].
  - Address 0 always reads 0 and is never busy.
- RUN, writes:
  - Take effect at the edge; writes to address 0 are discarded.
  - Both ports enabled with the same address: port B data is stored.
- RUN, scoreboard:
  - rsv_en sets busy[rsv_addr] at the edge.
  - Any enabled write (A or B) clears busy[addr] at the edge.
  - Set and clear on the same address in the same cycle: set wins, since the reservation is a newer producer.
  - busy[0] is held at 0.
- rd_busy[i] = busy[rd_addr[i]], combinational.
- Reset values: ready=0, rd_busy=0, rd_data=0.
- No wrap-around beyond DEPTH; the clear pointer is ADDR_W+1 bits wide to detect completion.

Optional Feature:
Macro REGFILE_BYPASS_EN.
- Defined:
  - A read whose address matches an enabled write in the same RUN cycle returns the write data combinationally; port B takes priority over A.
  - rd_busy for that port is forced to 0 unless rsv_en targets the same address in that cycle.
  - Address 0 is never bypassed.
- Undefined: reads return the pre-edge array value, and the new value is visible the cycle after the write.

Decomposition:
- Package regfile_pkg holds:
  - state enum {CLEAR, RUN}
  - localparam helpers for DEPTH and the clear-pointer width
  - ZERO_ADDR constant
- One natural sub-module, regfile_scoreboard:
  - Contains the busy bit vector, set/clear priority and the per-port busy lookup.
  - Instantiated once.

Test Plan:
1. rst high 1 cycle, then low -> ready=0 for exactly 32 cycles, then 1; every address reads 0.
2. In RUN: wa_en=1, wa_addr=5, wa_data=0xDEADBEEF; next cycle rd_addr[0]=5 -> rd_data port0=0xDEADBEEF. Write 0x1234 to address 0 -> reads 0.
3. wa and wb both to address 7, A=0x11, B=0x22 -> address 7 reads 0x22.
4. rsv_en, rsv_addr=9 -> rd_busy=1 for address 9. Then wb_en to address 9 -> busy=0 next cycle. Same-cycle rsv and write to address 9 -> busy stays 1.
5. rst asserted at clear pointer=10 with stale data preloaded -> clear restarts; ready rises 32 cycles after release; no stale data remains.
6. With REGFILE_BYPASS_EN: wa writes 0xAA to address 3 while rd_addr=3 -> same-cycle rd_data=0xAA. Without the macro -> old value that cycle, 0xAA the next.
